// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin bus-ownership arbiter for the shared Wishbone crossbar.
// Grants the shared master-to-slave path to one of N_MASTER masters.
// The owner keeps the grant while its cyc is high. An asserted lock holds
// the grant through cyc gaps. Every handover passes through at least one
// cycle with no grant.
//
// Optional watchdog: define WB_ARB_TIMEOUT_EN to build a stall counter. The
// counter pulses timeout_o after TIMEOUT_CYCLES consecutive stalled strobes
// from the owner. With the macro undefined, timeout_o is tied low.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   cyc_i        per-master wb_cyc   [N_MASTER]
//   stb_i        per-master wb_stb   [N_MASTER]
//   lock_i       per-master wb_lock  [N_MASTER]
//   ack_i        muxed slave ack (watchdog only)
//   err_i        muxed slave err (watchdog only)
//   rty_i        muxed slave rty (watchdog only)
//   gnt_o        one-hot grant, or all zero (registered)
//   gnt_idx_o    owner index, meaningful when gnt_valid_o=1 (registered)
//   gnt_valid_o  an owner exists (registered, equals |gnt_o)
//   timeout_o    one-cycle watchdog pulse (registered)
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int N_MASTER       = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDXW           = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_MASTER-1:0] cyc_i,
   input  logic [N_MASTER-1:0] stb_i,
   input  logic [N_MASTER-1:0] lock_i,
   input  logic                ack_i,
   input  logic                err_i,
   input  logic                rty_i,
   output logic [N_MASTER-1:0] gnt_o,
   output logic [IDXW-1:0]     gnt_idx_o,
   output logic                gnt_valid_o,
   output logic                timeout_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      LOCKED
   } state_e;

   state_e              state_q, state_d;
   logic [IDXW-1:0]     owner_q, owner_d;
   logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [N_MASTER-1:0] gnt_q, gnt_d;
   logic                gnt_valid_q, gnt_valid_d;

   logic [IDXW-1:0]     pick;
   logic [IDXW-1:0]     next_ptr;

   // First requester at or above rr_ptr, wrapping to 0.
   always_comb begin
      int unsigned idx;
      logic        found;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= N_MASTER) begin
            idx = idx - N_MASTER;
         end
         if (!found && cyc_i[IDXW'(idx)]) begin
            found = 1'b1;
            pick  = IDXW'(idx);
         end
      end
   end

   // Pointer value that follows the current owner, wrapping at N_MASTER-1.
   always_comb begin
      if (owner_q == IDXW'(N_MASTER - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = owner_q + IDXW'(1);
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|cyc_i) begin
               state_d = BUSY;
               owner_d = pick;
            end
         end
         BUSY: begin
            if (!cyc_i[owner_q]) begin
               if (lock_i[owner_q]) begin
                  state_d = LOCKED;
               end else begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end
            end
         end
         LOCKED: begin
            if (cyc_i[owner_q]) begin
               state_d = BUSY;
            end else if (!lock_i[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: grant registers follow the next state, so a release
   // clears gnt_o in the same edge that returns the FSM to IDLE. The IDLE
   // arbitration cycle that follows guarantees the zero-grant gap.
   always_comb begin
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      if (state_d != IDLE) begin
         gnt_d[owner_d] = 1'b1;
         gnt_valid_d    = 1'b1;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = owner_q;
   assign gnt_valid_o = gnt_valid_q;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wd_cnt_q, wd_cnt_d;
   logic          timeout_q, timeout_d;
   logic          term;

   assign term = ack_i | err_i | rty_i;

   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = 1'b0;
      if (state_q == IDLE || state_d == IDLE) begin
         // No owner now or ownership ends this cycle
         wd_cnt_d = '0;
      end else if (state_q == BUSY && stb_i[owner_q] && !term) begin
         if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            wd_cnt_d  = '0;
         end else begin
            wd_cnt_d = wd_cnt_q + CW'(1);
         end
      end else if (!stb_i[owner_q] || term) begin
         wd_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_wd;
   assign unused_wd = ^{stb_i, ack_i, err_i, rty_i, (32'(TIMEOUT_CYCLES) != 0)};
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] cyc_i, stb_i, lock_i;
   logic       ack_i, err_i, rty_i;
   logic [3:0] gnt_o;
   logic [1:0] gnt_idx_o;
   logic       gnt_valid_o;
   logic       timeout_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   wb_rr_arbiter #(
      .N_MASTER       (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cyc_i       (cyc_i),
      .stb_i       (stb_i),
      .lock_i      (lock_i),
      .ack_i       (ack_i),
      .err_i       (err_i),
      .rty_i       (rty_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rst;
      logic [3:0] cyc;
      logic [3:0] lock;
      logic [3:0] exp_gnt;
      logic [1:0] exp_idx;
      logic       chk_idx;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] cyc,
                               input logic [3:0] lock, input logic [3:0] gnt,
                               input logic [1:0] idx, input logic chk);
      vec_t v;
      v.rst = rst; v.cyc = cyc; v.lock = lock;
      v.exp_gnt = gnt; v.exp_idx = idx; v.chk_idx = chk;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic [3:0] cyc, input logic [3:0] lock,
                       input logic ack);
      rst_i  = rst;
      cyc_i  = cyc;
      stb_i  = cyc;
      lock_i = lock;
      ack_i  = ack;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "tb timeout");
   end

   initial begin
      rst_i = 1'b1; cyc_i = '0; stb_i = '0; lock_i = '0;
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;

      // Reset, single requester 2, release -> rr_ptr=3
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
      // All request; order 3,0,1,2,3 with one gap cycle each
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(0, 4'b0111, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1));
      tbl.push_back(mk(0, 4'b1110, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b1101, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1));
      tbl.push_back(mk(0, 4'b1011, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(0, 4'b0111, 4'b0000, 4'b0000, 2'd0, 0));
      // Lock: master 1 holds through cyc gaps while master 0 requests
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0010, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0010, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0010, 4'b0010, 2'd1, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1));
      // cyc and lock dropping together from BUSY is a plain release
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
      // rr_ptr=1: master 3 wins, then reset mid-BUSY
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1));
      tbl.push_back(mk(1, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1));
      tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1));
      tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].cyc, tbl[i].lock, 1'b0);
         check($sformatf("row%0d_gnt", i), 32'(gnt_o), 32'(tbl[i].exp_gnt));
         check($sformatf("row%0d_valid", i), 32'(gnt_valid_o), 32'(|tbl[i].exp_gnt));
         check($sformatf("row%0d_timeout", i), 32'(timeout_o), 32'd0);
         if (tbl[i].chk_idx) begin
            check($sformatf("row%0d_idx", i), 32'(gnt_idx_o), 32'(tbl[i].exp_idx));
         end
      end

`ifdef WB_ARB_TIMEOUT_EN
      // Continuous stall: pulses after 8 and 16 stalled cycles
      step(1, 4'b0000, 4'b0000, 1'b0);
      step(0, 4'b0001, 4'b0000, 1'b0);
      check("to_grant", 32'(gnt_o), 32'h1);
      for (int j = 1; j <= 16; j++) begin
         step(0, 4'b0001, 4'b0000, 1'b0);
         check($sformatf("to_stall%0d", j), 32'(timeout_o), 32'((j == 8) || (j == 16)));
         check($sformatf("to_stall%0d_gnt", j), 32'(gnt_o), 32'h1);
      end
      // Ack on stall cycle 7 restarts the count
      step(1, 4'b0000, 4'b0000, 1'b0);
      step(0, 4'b0001, 4'b0000, 1'b0);
      check("ack_grant", 32'(gnt_o), 32'h1);
      for (int j = 1; j <= 15; j++) begin
         step(0, 4'b0001, 4'b0000, (j == 7));
         check($sformatf("ack_cyc%0d", j), 32'(timeout_o), 32'(j == 15));
      end
`else
      step(1, 4'b0000, 4'b0000, 1'b0);
      check("nt_reset_gnt", 32'(gnt_o), 32'h0);
      step(0, 4'b0001, 4'b0000, 1'b0);
      check("nt_grant", 32'(gnt_o), 32'h1);
      for (int j = 1; j <= 100; j++) begin
         step(0, 4'b0001, 4'b0000, 1'b0);
         check($sformatf("nt_stall%0d", j), 32'(timeout_o), 32'd0);
         check($sformatf("nt_stall%0d_gnt", j), 32'(gnt_o), 32'h1);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
